// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract: STAGES carry-chained slices, one per clock,
// with a valid/ready handshake on both sides and a synchronous flush.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int CH = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic             ovf_q;
  logic             zero_q;
  logic             init_q;

  logic             v_d [STAGES];
  logic             c_d [STAGES];
  logic             ci  [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] r_d [STAGES];
  logic [STAGES:0]  rdy;
  logic [CH:0]      slc;
  logic             ovf_d;
  logic             zero_d;

  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--)
      rdy[k] = !v_q[k] || rdy[k+1];
    in_ready = init_q && !flush && rdy[0];

    // Stage 0 consumes the raw operands; carry-in of 1 completes ~b + 1
    a_d[0] = a;
    b_d[0] = b ^ {WIDTH{sub}};
    r_d[0] = '0;
    ci[0]  = sub;
    v_d[0] = in_valid && in_ready;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
      r_d[k] = r_q[k-1];
      ci[k]  = c_q[k-1];
      v_d[k] = v_q[k-1];
    end

    slc = '0;
    for (int k = 0; k < STAGES; k++) begin
      slc = {1'b0, a_d[k][k*CH +: CH]}
          + {1'b0, b_d[k][k*CH +: CH]}
          + (CH+1)'(ci[k]);
      c_d[k] = slc[CH];
      r_d[k][k*CH +: CH] = slc[CH-1:0];
    end

    ovf_d  = (a_d[L][WIDTH-1] == b_d[L][WIDTH-1])
          && (r_d[L][WIDTH-1] != a_d[L][WIDTH-1]);
    zero_d = ~|r_d[L];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else begin
      init_q <= 1'b1;
      for (int k = 0; k < STAGES; k++) begin
        if (flush) begin
          v_q[k] <= 1'b0;
        end else if (rdy[k]) begin
          v_q[k] <= v_d[k];
          c_q[k] <= c_d[k];
          a_q[k] <= a_d[k];
          b_q[k] <= b_d[k];
          r_q[k] <= r_d[k];
        end
      end
      if (!flush && rdy[L]) begin
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign out_valid = v_q[L];
  assign sum       = r_q[L];
  assign carry_out = c_q[L];
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined add/subtract unit that splits a WIDTH-bit operation into STAGES equal carry-chained slices, one slice per clock. The carry between slices is registered, and operand bits not yet consumed are skewed forward through pipeline registers. A valid/ready handshake on both sides gives full throughput with back-pressure. A synchronous flush squashes in-flight operations. It is the multi-cycle, parametrised successor to the single-bit full adder, intended for wide arithmetic paths in the pipelined RV32 datapath where a single-cycle WIDTH-bit carry chain misses timing.

## Interface
- WIDTH, 32: operand and result width in bits; must be a multiple of STAGES.
- STAGES, 4: number of pipeline slices; 1 ≤ STAGES ≤ WIDTH. Slice width CH = WIDTH/STAGES.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous squash of all in-flight operations.
- in_valid  input  1  operands on a, b, sub are valid.
- in_ready  output  1  unit accepts an operation this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 computes a+b; 1 computes a−b (a + ~b + 1).
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result modulo 2^WIDTH.
- carry_out  output  1  carry from the MSB. For subtraction, 1 means no borrow (a ≥ b unsigned).
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

## Operation
- Each stage k (1..STAGES) holds the following registers:
  - valid v[k] and carry c[k];
  - low k·CH result bits;
  - the remaining unconsumed slices of a and of effective B (b ^ {WIDTH{sub}});
  - sign bits a_msb and beff_msb.
- Stage 1 adds slice 0 with carry-in = sub.
- Stage k adds slice k−1 using c[k−1].
- Stage STAGES drives the outputs.
- Handshake:
  - Transfer in on in_valid && in_ready.
  - Transfer out on out_valid && out_ready.
- Stage advance: rdy[STAGES+1] = out_ready; rdy[k] = !v[k] || rdy[k+1]; in_ready = rdy[1].
- A stage with rdy[k] = 0 holds all its registers unchanged.
- out_valid = v[STAGES].
- Flags, from the final stage only:
  - carry_out = final slice carry;
  - overflow = (a_msb == beff_msb) && (sum[WIDTH−1] != a_msb);
  - zero = ~|sum.
- Wrap-around: sum is modulo 2^WIDTH. 0xFFFFFFFF + 1 gives sum = 0, carry_out = 1, zero = 1, overflow = 0.
- flush:
  - Clears every v[k] on the next edge. Data registers may keep stale values.
  - in_ready is forced to 0 during the flush cycle, so no operation is accepted.
  - flush takes priority over advance and over out_ready.
- STAGES = 1 degenerates to a single registered adder with latency 1.

## Timing
- Reset (rst low, asynchronous):
  - all v[k] = 0, so out_valid = 0;
  - sum = 0, carry_out = 0, overflow = 0, zero = 0;
  - in_ready = 1 one cycle after rst deasserts. in_ready is low while rst is asserted.
- Reset asserted mid-operation drops all in-flight operations immediately. No output handshake completes for them.
- Latency: an operation accepted at edge t has out_valid high after edge t+STAGES−1, i.e. visible in cycle t+STAGES, when there is no back-pressure.
- Throughput: one operation per cycle while out_ready stays high.
- Back-pressure:
  - While out_valid && !out_ready, sum, carry_out, overflow and zero stay stable.
  - The pipeline compresses bubbles, then stalls.
  - in_ready falls only when all STAGES registers are valid and out_ready = 0.
  - Full: the unit holds exactly STAGES operations.
- Simultaneous input accept and output transfer on a full pipeline is allowed: in_ready = 1 when out_ready = 1.
- in_ready depends combinationally on out_ready (ready chain). out_valid and all result fields are registered.
- Order is strictly FIFO. No operation is dropped or duplicated except by flush or reset.

## Test plan
- WIDTH = 32, STAGES = 4, out_ready = 1:
  - a = 0x0000_00FF, b = 0x0000_0001, sub = 0 → after 4 cycles, sum = 0x0000_0100, carry_out = 0, zero = 0. Carry crosses the slice 0→1 boundary.
- Wrap and flags:
  - 0xFFFF_FFFF + 0x0000_0001 → sum = 0, carry_out = 1, zero = 1, overflow = 0.
  - 0x7FFF_FFFF + 1 → sum = 0x8000_0000, overflow = 1, carry_out = 0.
- Subtract:
  - 5 − 7 → sum = 0xFFFF_FFFE, carry_out = 0.
  - 0x8000_0000 − 1 → sum = 0x7FFF_FFFF, overflow = 1.
- Streaming and back-pressure:
  - Issue 10 back-to-back ops (a = i, b = 2i), with out_ready low for cycles 6–9.
  - Results 3i arrive in order, none lost.
  - in_ready drops exactly when 4 ops are held.
  - Outputs stay stable while stalled.
- Flush and reset:
  - Issue 3 ops, assert flush for 1 cycle → no out_valid for them; the next op issued afterwards completes normally.
  - Assert rst mid-stream → out_valid falls immediately and all outputs read 0.
- Parameter sweep: repeat random add/sub against a golden model for (WIDTH, STAGES) = (8, 1), (16, 2), (32, 8), (64, 4).
